// File: rtl/cla8_pkg.sv
// ---------------------------------------------------------------------------
// cla8_pkg
// Shared definitions for the CLA8 operation sequencer and its bench.
//   cla8_state_e    : sequencer FSM states (IDLE, SETTLE, RESP)
//   CLA8_W          : datapath width of the carry-lookahead adder
//   CLA8_SETTLE_DEF : default settle time, in clock cycles
// ---------------------------------------------------------------------------
package cla8_pkg;

  localparam int CLA8_W          = 8;
  localparam int CLA8_SETTLE_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } cla8_state_e;

endpackage

// File: rtl/cla8_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// cla8_op_sequencer_if
// Bundles the three buses around the sequencer:
//   req_*  : request handshake (valid/ready) with operands and op type
//   cla_*  : registered operands out to the CLA, sum/carry back from it
//   rsp_*  : response handshake (valid/ready) with captured result and flags
// Modports:
//   slave  : the sequencer's view
//   master : the environment's view (requester, consumer and CLA together)
// ---------------------------------------------------------------------------
interface cla8_op_sequencer_if;
  import cla8_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [CLA8_W-1:0] req_a;
  logic [CLA8_W-1:0] req_b;
  logic              req_cin;
  logic              req_sub;

  logic [CLA8_W-1:0] cla_a;
  logic [CLA8_W-1:0] cla_b;
  logic              cla_cin;
  logic [CLA8_W-1:0] cla_sum;
  logic              cla_cout;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [CLA8_W-1:0] rsp_sum;
  logic              rsp_cout;
  logic              rsp_ovf;
  logic              rsp_zero;

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_sub,
    input  cla_sum, cla_cout,
    input  rsp_ready,
    output req_ready,
    output cla_a, cla_b, cla_cin,
    output rsp_valid, rsp_sum, rsp_cout, rsp_ovf, rsp_zero
  );

  modport master (
    output req_valid, req_a, req_b, req_cin, req_sub,
    output cla_sum, cla_cout,
    output rsp_ready,
    input  req_ready,
    input  cla_a, cla_b, cla_cin,
    input  rsp_valid, rsp_sum, rsp_cout, rsp_ovf, rsp_zero
  );

endinterface

// File: rtl/cla8_flags.sv
// ---------------------------------------------------------------------------
// cla8_flags
// Combinational result flags for an addition a + b_eff (+ carry).
// Subtraction is presented here already folded into b_eff (inverted B),
// so one overflow rule covers both operations.
//   a     in  CLA8_W  first operand as launched into the CLA
//   b_eff in  CLA8_W  effective second operand as launched into the CLA
//   sum   in  CLA8_W  CLA sum
//   ovf   out 1       two's-complement overflow
//   zero  out 1       sum is all zeros
// ---------------------------------------------------------------------------
module cla8_flags
  import cla8_pkg::*;
(
  input  logic [CLA8_W-1:0] a,
  input  logic [CLA8_W-1:0] b_eff,
  input  logic [CLA8_W-1:0] sum,
  output logic              ovf,
  output logic              zero
);

  // Overflow: both operands share a sign and the sum's sign differs from it.
  assign ovf  = (a[CLA8_W-1] == b_eff[CLA8_W-1]) && (sum[CLA8_W-1] != a[CLA8_W-1]);
  assign zero = (sum == '0);

endmodule

// File: rtl/cla8_op_sequencer.sv
// ---------------------------------------------------------------------------
// cla8_op_sequencer
// Sequential driver/consumer for the combinational gate-delay CLA.
// Accepts an add/subtract request, launches registered operands into the
// CLA, waits SETTLE_CYCLES clocks for the gate-delay cells to resolve,
// captures sum/carry plus flags, and offers them on a response handshake.
// Parameters:
//   SETTLE_CYCLES  launch-to-capture distance in clocks, legal 1..15
// Ports:
//   clk  in  1  rising-edge clock
//   rst  in  1  asynchronous active-high reset
//   bus  cla8_op_sequencer_if.slave  request, CLA and response buses
// ---------------------------------------------------------------------------
module cla8_op_sequencer
  import cla8_pkg::*;
#(
  parameter int SETTLE_CYCLES = CLA8_SETTLE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  cla8_op_sequencer_if.slave bus
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  cla8_state_e       r_state;
  logic [3:0]        r_cnt;
  logic [CLA8_W-1:0] r_claA;
  logic [CLA8_W-1:0] r_claB;
  logic              r_claCin;
  logic [CLA8_W-1:0] r_rspSum;
  logic              r_rspCout;
  logic              r_rspOvf;
  logic              r_rspZero;
  logic              r_reqReady;
  logic              r_rspValid;

  logic              w_ovf;
  logic              w_zero;

  // Flags are evaluated against the operands actually in the CLA, so the
  // subtract case needs no special handling here.
  cla8_flags u_flags (
    .a     (r_claA),
    .b_eff (r_claB),
    .sum   (bus.cla_sum),
    .ovf   (w_ovf),
    .zero  (w_zero)
  );

  // Sequencer FSM. The op type is folded into cla_b/cla_cin at accept time
  // (A - B - borrow == A + ~B + ~borrow), so no separate copy of req_sub is
  // kept. req_ready/rsp_valid are registered alongside the state so they
  // never depend combinationally on req_valid or rsp_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_claA     <= '0;
      r_claB     <= '0;
      r_claCin   <= 1'b0;
      r_rspSum   <= '0;
      r_rspCout  <= 1'b0;
      r_rspOvf   <= 1'b0;
      r_rspZero  <= 1'b0;
      r_reqReady <= 1'b1;
      r_rspValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_claA     <= bus.req_a;
            r_claB     <= bus.req_b ^ {CLA8_W{bus.req_sub}};
            r_claCin   <= bus.req_cin ^ bus.req_sub;
            r_cnt      <= SETTLE_LOAD;
            r_reqReady <= 1'b0;
            r_state    <= SETTLE;
          end
        end

        SETTLE: begin
          r_cnt <= r_cnt - 4'd1;
          // cnt==1 marks the edge SETTLE_CYCLES clocks after the accept edge.
          if (r_cnt == 4'd1) begin
            r_rspSum   <= bus.cla_sum;
            r_rspCout  <= bus.cla_cout;
            r_rspOvf   <= w_ovf;
            r_rspZero  <= w_zero;
            r_rspValid <= 1'b1;
            r_state    <= RESP;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            r_rspValid <= 1'b0;
            r_reqReady <= 1'b1;
            r_state    <= IDLE;
          end
        end

        default: begin
          r_rspValid <= 1'b0;
          r_reqReady <= 1'b1;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = r_reqReady;
  assign bus.cla_a     = r_claA;
  assign bus.cla_b     = r_claB;
  assign bus.cla_cin   = r_claCin;
  assign bus.rsp_valid = r_rspValid;
  assign bus.rsp_sum   = r_rspSum;
  assign bus.rsp_cout  = r_rspCout;
  assign bus.rsp_ovf   = r_rspOvf;
  assign bus.rsp_zero  = r_rspZero;

endmodule
